// File: rtl/tile_reader.sv
// rtl/tile_reader.sv - sequential SRAM window scanner with 1-entry skid
// Issues one read per cycle over an inclusive wrapping window and presents {valid, addr, data}.
module tile_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_en,
  input  logic                  i_reg_clear,
  input  logic                  i_stall_en,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_end_addr,
  output logic                  o_sram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_valid_addr,
  output logic [ADDR_WIDTH-1:0] o_current_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;

  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;

  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic issue;
  logic consume;

  // A valid skid blocks issue, so at most one word can ever be waiting behind the output.
  assign issue   = (state_q == READ) & i_en & ~i_stall_en & ~skid_valid_q;
  assign consume = out_valid_q & i_en & ~i_stall_en;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    if (consume) begin
      if (skid_valid_q) begin
        out_addr_d   = skid_addr_q;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (pend_q) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_addr_d  = pend_addr_q;
        out_data_d  = i_sram_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_addr_d  = pend_addr_q;
        skid_data_d  = i_sram_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      pend_q       <= issue;
      pend_addr_q  <= cnt_q;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (i_en && i_start) begin
          cnt_d   = i_start_addr;
          rem_d   = {1'b0, i_end_addr - i_start_addr} + (ADDR_WIDTH+1)'(1);
          state_d = READ;
        end
      end
      READ: begin
        if (issue) begin
          cnt_d = cnt_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_WIDTH+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as this cycle's consume empties the pipeline, so o_done follows the last consume directly.
        if (i_en && !out_valid_d && !skid_valid_d && !pend_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_sram_rd_en = issue;
    o_sram_addr  = cnt_q;
    o_busy       = (state_q != IDLE);
    o_done       = (state_q == DONE);
  end

  assign o_valid_addr   = out_valid_q;
  assign o_current_addr = out_addr_q;
  assign o_data         = out_data_q;

endmodule
